// File: rtl/bram_matmul_scheduler.sv
// Block-matmul read scheduler: walks (r, c, k) with k innermost, issues paired
// input/weight BRAM reads, and delays valid/first/last/index tags by the BRAM
// read latency so they line up with the returned data at the compute core.
//
// Flow control: hold is a downstream stall. A read is issued (both enables
// high) only in RUN with hold=0. A held cycle issues nothing, freezes the loop
// counters and the tag pipeline, and never presents core_valid; a beat that
// would have been presented is instead shown on the next un-held cycle.
module bram_matmul_scheduler #(
    parameter int ADDR_WIDTH_A = 8,
    parameter int ADDR_WIDTH_B = 8,
    parameter int N_ROW        = 2,
    parameter int N_COL        = 3,
    parameter int N_INNER      = 4,
    parameter int BRAM_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    in_mat_enb,
    output logic [ADDR_WIDTH_A-1:0] in_mat_rd_addrb,
    output logic                    w_mat_enb,
    output logic [ADDR_WIDTH_B-1:0] w_mat_rd_addrb,
    output logic                    core_valid,
    output logic                    core_first,
    output logic                    core_last,
    output logic [15:0]             out_row,
    output logic [15:0]             out_col,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] R_LAST = 16'(N_ROW - 1);
    localparam logic [15:0] C_LAST = 16'(N_COL - 1);
    localparam logic [15:0] K_LAST = 16'(N_INNER - 1);
    localparam logic [31:0] NI     = 32'(N_INNER);

    state_t state_q, state_d;
    logic [15:0] r_q, r_d, c_q, c_d, k_q, k_d;

    // Tag pipeline: index 0 is loaded on issue, index BRAM_LAT-1 faces the core.
    logic [BRAM_LAT-1:0]       pv_q, pv_d, pf_q, pf_d, pl_q, pl_d;
    logic [BRAM_LAT-1:0][15:0] prow_q, prow_d, pcol_q, pcol_d;

    logic        issue;
    logic [31:0] addr_a_full, addr_b_full;

    assign issue = (state_q == S_RUN) && !hold;

    // Linear block addresses from the loop counters; zero outside RUN.
    always_comb begin
        addr_a_full = {16'd0, r_q} * NI + {16'd0, k_q};
        addr_b_full = {16'd0, c_q} * NI + {16'd0, k_q};
        in_mat_enb      = issue;
        w_mat_enb       = issue;
        in_mat_rd_addrb = '0;
        w_mat_rd_addrb  = '0;
        if (state_q == S_RUN) begin
            in_mat_rd_addrb = addr_a_full[ADDR_WIDTH_A-1:0];
            w_mat_rd_addrb  = addr_b_full[ADDR_WIDTH_B-1:0];
        end
    end

    // Shift the tag pipeline on every un-held cycle, loading the current issue.
    always_comb begin
        pv_d   = pv_q;
        pf_d   = pf_q;
        pl_d   = pl_q;
        prow_d = prow_q;
        pcol_d = pcol_q;
        if (!hold) begin
            for (int i = 1; i < BRAM_LAT; i++) begin
                pv_d[i]   = pv_q[i-1];
                pf_d[i]   = pf_q[i-1];
                pl_d[i]   = pl_q[i-1];
                prow_d[i] = prow_q[i-1];
                pcol_d[i] = pcol_q[i-1];
            end
            pv_d[0]   = issue;
            pf_d[0]   = issue && (k_q == 16'd0);
            pl_d[0]   = issue && (k_q == K_LAST);
            prow_d[0] = r_q;
            pcol_d[0] = c_q;
        end
    end

    // Next-state and loop-counter logic; k innermost, then c, then r.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (c_q == C_LAST) begin
                            c_d = '0;
                            if (r_q == R_LAST) begin
                                r_d     = '0;
                                state_d = S_DRAIN;
                            end else begin
                                r_d = r_q + 16'd1;
                            end
                        end else begin
                            c_d = c_q + 16'd1;
                        end
                    end else begin
                        k_d = k_q + 16'd1;
                    end
                end
            end
            // Leave once the beat on the output is the last one in flight.
            S_DRAIN: begin
                if (pv_d == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and pipeline registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            pv_q    <= '0;
            pf_q    <= '0;
            pl_q    <= '0;
            prow_q  <= '0;
            pcol_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            pv_q    <= pv_d;
            pf_q    <= pf_d;
            pl_q    <= pl_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
        end
    end

    // Core-side outputs come straight off the last pipeline stage.
    always_comb begin
        core_valid = pv_q[BRAM_LAT-1] && !hold;
        core_first = pf_q[BRAM_LAT-1] && core_valid;
        core_last  = pl_q[BRAM_LAT-1] && core_valid;
        out_row    = prow_q[BRAM_LAT-1];
        out_col    = pcol_q[BRAM_LAT-1];
        busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
        done       = (state_q == S_DONE);
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_bram_matmul_scheduler.sv
module tb_bram_matmul_scheduler;

    logic clk = 1'b0;
    logic rst, start, hold, sel;
    always #5 clk = ~clk;

    // Instance 0: default parameters. Instance 1: single-beat configuration.
    logic        enb0, wenb0, v0, f0, l0, busy0, done0;
    logic [7:0]  a0, b0;
    logic [15:0] row0, col0;
    logic [1:0]  st0;
    logic        enb1, wenb1, v1, f1, l1, busy1, done1;
    logic [7:0]  a1, b1;
    logic [15:0] row1, col1;
    logic [1:0]  st1;
    logic        start0, start1;

    assign start0 = start && !sel;
    assign start1 = start && sel;

    bram_matmul_scheduler dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold(hold),
        .in_mat_enb(enb0), .in_mat_rd_addrb(a0),
        .w_mat_enb(wenb0), .w_mat_rd_addrb(b0),
        .core_valid(v0), .core_first(f0), .core_last(l0),
        .out_row(row0), .out_col(col0), .busy(busy0), .done(done0),
        .dbg_state(st0)
    );

    bram_matmul_scheduler #(
        .N_ROW(1), .N_COL(1), .N_INNER(1), .BRAM_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold),
        .in_mat_enb(enb1), .in_mat_rd_addrb(a1),
        .w_mat_enb(wenb1), .w_mat_rd_addrb(b1),
        .core_valid(v1), .core_first(f1), .core_last(l1),
        .out_row(row1), .out_col(col1), .busy(busy1), .done(done1),
        .dbg_state(st1)
    );

    // Selected instance outputs.
    logic        m_enb, m_wenb, m_v, m_f, m_l, m_busy, m_done;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_row, m_col;
    logic [1:0]  m_st;
    always_comb begin
        if (sel) begin
            {m_enb, m_wenb, m_v, m_f, m_l, m_busy, m_done} = {enb1, wenb1, v1, f1, l1, busy1, done1};
            {m_a, m_b, m_row, m_col, m_st} = {a1, b1, row1, col1, st1};
        end else begin
            {m_enb, m_wenb, m_v, m_f, m_l, m_busy, m_done} = {enb0, wenb0, v0, f0, l0, busy0, done0};
            {m_a, m_b, m_row, m_col, m_st} = {a0, b0, row0, col0, st0};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a list of reads still to issue, and a list of issued
    // reads each due at a given count of un-held cycles.
    int m_nrow, m_ncol, m_ninner, m_lat;
    int ucount, cyc;
    bit busy_m, run_m, done_next, mon_en;
    logic [47:0] exp_q[$];
    logic [47:0] pend_tag[$];
    int          pend_due[$];

    // Per-run observations of the actual outputs.
    int beats, lasts, groups, done_cnt, issues;
    int first_issue_cyc, first_valid_cyc, last_valid_cyc, done_cyc;
    bit open_grp;
    logic [7:0] alog[$];
    logic [7:0] blog[$];

    task automatic set_cfg(input int nr, input int nc, input int ni, input int lat);
        m_nrow = nr; m_ncol = nc; m_ninner = ni; m_lat = lat;
    endtask

    task automatic reset_model();
        busy_m = 0; run_m = 0; done_next = 0; ucount = 0;
        exp_q.delete(); pend_tag.delete(); pend_due.delete();
    endtask

    task automatic reset_stats();
        beats = 0; lasts = 0; groups = 0; done_cnt = 0; issues = 0; open_grp = 0;
        first_issue_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
        alog.delete(); blog.delete();
    endtask

    logic [47:0] tag;
    logic [31:0] ea, eb;
    bit h, s, enb_exp, valid_exp, idle_now, nd;

    // Compare process: every cycle outside reset, against the model.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            cyc++;
            h = hold;
            s = start;
            idle_now = !busy_m && !done_next;
            if (!h) ucount++;
            enb_exp = run_m && !h;
            chk("in_mat_enb", 32'(m_enb), 32'(enb_exp));
            chk("w_mat_enb", 32'(m_wenb), 32'(enb_exp));
            if (run_m && exp_q.size() > 0) begin
                tag = exp_q[0];
                ea = (32'(tag[47:32]) * 32'(m_ninner) + 32'(tag[15:0])) & 32'hFF;
                eb = (32'(tag[31:16]) * 32'(m_ninner) + 32'(tag[15:0])) & 32'hFF;
                chk("in_mat_rd_addrb", 32'(m_a), ea);
                chk("w_mat_rd_addrb", 32'(m_b), eb);
            end
            valid_exp = !h && pend_due.size() > 0 && pend_due[0] == ucount;
            chk("core_valid", 32'(m_v), 32'(valid_exp));
            if (valid_exp) begin
                tag = pend_tag[0];
                chk("core_first", 32'(m_f), 32'(tag[15:0] == 16'd0));
                chk("core_last", 32'(m_l), 32'(32'(tag[15:0]) == 32'(m_ninner - 1)));
                chk("out_row", 32'(m_row), 32'(tag[47:32]));
                chk("out_col", 32'(m_col), 32'(tag[31:16]));
            end
            chk("done", 32'(m_done), 32'(done_next));
            chk("busy", 32'(m_busy), 32'(busy_m));

            if (m_enb) begin
                issues++;
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                alog.push_back(m_a);
                blog.push_back(m_b);
            end
            if (m_v) begin
                beats++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
                if (m_f) open_grp = 1;
                if (m_l) begin
                    lasts++;
                    if (open_grp) groups++;
                    open_grp = 0;
                end
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            nd = 0;
            if (enb_exp) begin
                tag = exp_q.pop_front();
                pend_tag.push_back(tag);
                pend_due.push_back(ucount + m_lat);
                if (exp_q.size() == 0) run_m = 0;
            end
            if (valid_exp) begin
                void'(pend_tag.pop_front());
                void'(pend_due.pop_front());
                if (pend_due.size() == 0 && !run_m) begin
                    nd = 1;
                    busy_m = 0;
                end
            end
            if (idle_now && s) begin
                busy_m = 1;
                run_m = 1;
                for (int r = 0; r < m_nrow; r++)
                    for (int c = 0; c < m_ncol; c++)
                        for (int k = 0; k < m_ninner; k++)
                            exp_q.push_back({16'(r), 16'(c), 16'(k)});
            end
            done_next = nd;
        end
    end

    task automatic step(input bit s_i, input bit h_i);
        start = s_i;
        hold = h_i;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        int base = done_cnt;
        while (done_cnt == base && n < budget) begin
            step(0, 0);
            n++;
        end
        chk(name, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_enables"}, 32'({m_enb, m_wenb}), 32'd0);
        chk({name, "_addrs"}, 32'({m_a, m_b}), 32'd0);
        chk({name, "_core"}, 32'({m_v, m_f, m_l}), 32'd0);
        chk({name, "_idx"}, {m_row, m_col}, 32'd0);
        chk({name, "_busy_done_state"}, 32'({m_busy, m_done, m_st}), 32'd0);
    endtask

    task automatic check_full_run(input string name);
        chk({name, "_beats"}, 32'(beats), 32'd24);
        chk({name, "_issues"}, 32'(issues), 32'd24);
        chk({name, "_lasts"}, 32'(lasts), 32'd6);
        chk({name, "_groups"}, 32'(groups), 32'd6);
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({name, "_done_after_last"}, 32'(done_cyc - last_valid_cyc), 32'd1);
    endtask

    initial begin
        int n;
        cyc = 0; mon_en = 0; sel = 0;
        start = 0; hold = 0; rst = 1;
        set_cfg(2, 3, 4, 2);
        reset_model();
        reset_stats();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 0;
        mon_en = 1;
        step(0, 0);
        step(0, 0);

        // Plain run with default parameters.
        reset_stats();
        step(1, 0);
        wait_done("run_a_timeout", 200);
        step(0, 0);
        check_full_run("run_a");
        chk("run_a_addr_a0", 32'(alog[0]), 32'd0);
        chk("run_a_addr_a1", 32'(alog[1]), 32'd1);
        chk("run_a_addr_a3", 32'(alog[3]), 32'd3);
        chk("run_a_addr_a4", 32'(alog[4]), 32'd0);
        chk("run_a_addr_b4", 32'(blog[4]), 32'd4);
        chk("run_a_addr_b23", 32'(blog[23]), 32'd11);
        chk("run_a_addr_a23", 32'(alog[23]), 32'd7);
        chk("run_a_latency", 32'(first_valid_cyc - first_issue_cyc), 32'd2);

        // Three held cycles mid-run.
        reset_stats();
        step(1, 0);
        repeat (5) step(0, 0);
        repeat (3) step(0, 1);
        wait_done("run_b_timeout", 200);
        step(0, 0);
        check_full_run("run_b");
        chk("run_b_resume_a", 32'(alog[5]), 32'd1);
        chk("run_b_resume_b", 32'(blog[5]), 32'd5);

        // Start re-pulsed during RUN.
        reset_stats();
        step(1, 0);
        repeat (4) step(0, 0);
        step(1, 0);
        wait_done("run_c_timeout", 200);
        repeat (10) step(0, 0);
        check_full_run("run_c");

        // Reset during DRAIN, then a fresh run.
        reset_stats();
        step(1, 0);
        n = 0;
        while (!(busy_m && !run_m) && n < 100) begin
            step(0, 0);
            n++;
        end
        chk("run_d_reach_drain", 32'(busy_m && !run_m), 32'd1);
        chk("run_d_busy_in_drain", 32'(m_busy), 32'd1);
        rst = 1;
        mon_en = 0;
        #1;
        chk_zero("rst_in_drain");
        @(posedge clk);
        #1;
        rst = 0;
        reset_model();
        reset_stats();
        mon_en = 1;
        repeat (6) step(0, 0);
        chk("run_d_no_residual", 32'(beats + done_cnt), 32'd0);
        step(1, 0);
        wait_done("run_d_timeout", 200);
        step(0, 0);
        check_full_run("run_d");

        // Single-beat configuration.
        sel = 1;
        set_cfg(1, 1, 1, 1);
        reset_model();
        reset_stats();
        step(0, 0);
        step(1, 0);
        wait_done("run_e_timeout", 50);
        step(0, 0);
        chk("run_e_beats", 32'(beats), 32'd1);
        chk("run_e_first_last_group", 32'(groups), 32'd1);
        chk("run_e_latency", 32'(first_valid_cyc - first_issue_cyc), 32'd1);
        chk("run_e_done_after_last", 32'(done_cyc - last_valid_cyc), 32'd1);
        chk("run_e_done_cnt", 32'(done_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
